// File: rtl/controlador_cafe_if.sv
// Coin, request and display signals between the coffee machine front panel and the credit controller.
interface controlador_cafe_if;
  logic       moneda1;
  logic       moneda5;
  logic       pedir;
  logic [1:0] seleccion;
  logic       cancelar;
  logic [3:0] saldo;
  logic       servir;
  logic       cambio;
  logic       moneda_rechazada;
  logic       error_pedido;
  logic       ocupado;

  modport master (
    output moneda1, moneda5, pedir, seleccion, cancelar,
    input  saldo, servir, cambio, moneda_rechazada, error_pedido, ocupado
  );

  modport slave (
    input  moneda1, moneda5, pedir, seleccion, cancelar,
    output saldo, servir, cambio, moneda_rechazada, error_pedido, ocupado
  );
endinterface

// File: rtl/controlador_cafe.sv
// Credit controller: accumulates coins, validates drink requests, times the dispense
// strobe and pays back change one unit every other cycle. All outputs are registered.
module controlador_cafe #(
  parameter int unsigned PRECIO_0  = 3,
  parameter int unsigned PRECIO_1  = 5,
  parameter int unsigned PRECIO_2  = 7,
  parameter int unsigned SALDO_MAX = 15,
  parameter int unsigned T_SERVIR  = 8
) (
  input logic                clk,
  input logic                rst,
  controlador_cafe_if.slave  bus
);

  localparam int unsigned TW = $clog2(T_SERVIR) + 1;

  typedef enum logic [1:0] {
    REPOSO,
    ACUM,
    SERVIR,
    CAMBIO
  } estado_t;

  estado_t         state_q, state_d;
  logic [3:0]      saldo_q, saldo_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            fase_q, fase_d;
  logic            servir_q, servir_d;
  logic            cambio_q, cambio_d;
  logic            rech_q, rech_d;
  logic            err_q, err_d;
  logic            ocupado_q, ocupado_d;

  logic            moneda;
  logic            ambas;
  logic [4:0]      suma;
  logic [4:0]      precio;
  logic            sel_ok;

  // Arithmetic and compares are carried at 5 bits so overflow is visible before truncation.
  always_comb begin
    moneda = bus.moneda1 | bus.moneda5;
    ambas  = bus.moneda1 & bus.moneda5;
    suma   = {1'b0, saldo_q} + (bus.moneda5 ? 5'd5 : 5'd1);
    sel_ok = 1'b1;
    case (bus.seleccion)
      2'd0:    precio = 5'(PRECIO_0);
      2'd1:    precio = 5'(PRECIO_1);
      2'd2:    precio = 5'(PRECIO_2);
      default: begin
        precio = '0;
        sel_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    saldo_d  = saldo_q;
    timer_d  = timer_q;
    fase_d   = fase_q;
    servir_d = 1'b0;
    cambio_d = 1'b0;
    rech_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      REPOSO, ACUM: begin
        if (state_q == ACUM && bus.cancelar) begin
          state_d = CAMBIO;
          fase_d  = 1'b1;
          rech_d  = moneda;
        end else if (bus.pedir) begin
          rech_d = moneda;
          if (!sel_ok || ({1'b0, saldo_q} < precio)) begin
            err_d = 1'b1;
          end else begin
            saldo_d  = saldo_q - precio[3:0];
            state_d  = SERVIR;
            timer_d  = TW'(T_SERVIR - 1);
            servir_d = 1'b1;
          end
        end else if (moneda) begin
          if (ambas || (suma > 5'(SALDO_MAX))) begin
            rech_d = 1'b1;
          end else begin
            saldo_d = suma[3:0];
            state_d = ACUM;
          end
        end
      end

      SERVIR: begin
        rech_d = moneda;
        if (timer_q == '0) begin
          state_d = (saldo_q != '0) ? CAMBIO : REPOSO;
          fase_d  = 1'b1;
        end else begin
          timer_d  = timer_q - 1'b1;
          servir_d = 1'b1;
        end
      end

      CAMBIO: begin
        rech_d = moneda;
        // fase_q high means the next cycle pays a unit; low is the gap cycle.
        if (saldo_q == '0) begin
          state_d = REPOSO;
          fase_d  = 1'b0;
        end else if (fase_q) begin
          cambio_d = 1'b1;
          saldo_d  = saldo_q - 4'd1;
          fase_d   = 1'b0;
        end else begin
          fase_d = 1'b1;
        end
      end

      default: state_d = REPOSO;
    endcase

    ocupado_d = (state_d == SERVIR) || (state_d == CAMBIO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REPOSO;
      saldo_q   <= '0;
      timer_q   <= '0;
      fase_q    <= 1'b0;
      servir_q  <= 1'b0;
      cambio_q  <= 1'b0;
      rech_q    <= 1'b0;
      err_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saldo_q   <= saldo_d;
      timer_q   <= timer_d;
      fase_q    <= fase_d;
      servir_q  <= servir_d;
      cambio_q  <= cambio_d;
      rech_q    <= rech_d;
      err_q     <= err_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.saldo            = saldo_q;
  assign bus.servir           = servir_q;
  assign bus.cambio           = cambio_q;
  assign bus.moneda_rechazada = rech_q;
  assign bus.error_pedido     = err_q;
  assign bus.ocupado          = ocupado_q;

endmodule
